// File: rtl/serial_addsub_seq.sv
// Byte-serial multi-precision add/subtract sequencer sharing one 8-bit adder.
// Optional ADDSUB_FLAGS_EN adds registered zero/ovf flag outputs.
module serial_addsub_seq #(
    parameter int NBYTES = 4,
    localparam int WIDTH = 8 * NBYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef ADDSUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int IW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
`ifdef ADDSUB_FLAGS_EN
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               c7;
`endif

    logic [7:0]         byte_a, byte_b;
    logic [8:0]         sum9;
    logic               addr_byte;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: RUN keeps one extra cycle with idx == NBYTES to settle cout/flags
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (idx_q == IW'(NBYTES)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Operands shift right so the live byte is always at [7:0]
    always_comb begin
        byte_a    = a_q[7:0];
        byte_b    = b_q[7:0] ^ {8{mode_q}};
        sum9      = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, carry_q};
        addr_byte = (idx_q < IW'(NBYTES));
`ifdef ADDSUB_FLAGS_EN
        c7        = byte_a[7] ^ byte_b[7] ^ sum9[7];
`endif
    end

    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ADDSUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    idx_d    = '0;
                    carry_d  = mode;
                    result_d = '0;
                    cout_d   = 1'b0;
`ifdef ADDSUB_FLAGS_EN
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (addr_byte) begin
                    a_d     = a_q >> 8;
                    b_d     = b_q >> 8;
                    carry_d = sum9[8];
                    idx_d   = idx_q + 1'b1;
                    for (int i = 0; i < NBYTES; i++)
                        if (idx_q == IW'(i)) result_d[8*i +: 8] = sum9[7:0];
`ifdef ADDSUB_FLAGS_EN
                    if (idx_q == IW'(NBYTES - 1)) ovf_d = c7 ^ sum9[8];
`endif
                end else begin
                    cout_d = carry_q;
`ifdef ADDSUB_FLAGS_EN
                    zero_d = (result_q == '0);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
`ifdef ADDSUB_FLAGS_EN
    assign zero   = zero_q;
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Randomized self-checking bench for serial_addsub_seq against a plain-arithmetic model.
module tb_serial_addsub_seq;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, mode;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] result;
`ifdef ADDSUB_FLAGS_EN
    logic         zero, ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_addsub_seq #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef ADDSUB_FLAGS_EN
        .zero   (zero),
        .ovf    (ovf),
`endif
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: unsigned W-bit add / subtract with carry, signed overflow
    task automatic model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0]   full;
        logic [W-1:0] yy;
        if (m) begin
            full = {1'b0, x} - {1'b0, y};
            c    = (x >= y);
            yy   = ~y;
        end else begin
            full = {1'b0, x} + {1'b0, y};
            c    = full[W];
            yy   = y;
        end
        r = full[W-1:0];
        v = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    endtask

    task automatic do_op(input string tag, input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         ec, ev;
        int           cyc;
        model(m, x, y, er, ec, ev);
        @(negedge clk);
        start = 1'b1; mode = m; a = x; b = y;
        @(negedge clk);
        // scramble inputs after acceptance; operands must already be registered
        start = 1'b0; mode = ~m; a = W'($urandom); b = W'($urandom);
        chk({tag, ".busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'(NBYTES + 1));
        chk({tag, ".res"}, 64'(result), 64'(er));
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
`ifdef ADDSUB_FLAGS_EN
        chk({tag, ".zero"}, 64'(zero), 64'(er == '0));
        chk({tag, ".ovf"}, 64'(ovf), 64'(ev));
`endif
        @(negedge clk);
        chk({tag, ".pulse"}, 64'({done, busy}), 64'(0));
        chk({tag, ".hold"}, 64'(result), 64'(er));
    endtask

    initial begin
        logic [W-1:0] r1, r2, x1, y1, x2, y2;
        logic         c, v;
        int           n_done;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.res", 64'(result), 64'(0));
        chk("rst.cout", 64'(cout), 64'(0));
        rst = 1'b0;

        do_op("t1", 1'b0, 32'h0000_00FF, 32'h0000_0001);
        do_op("t2", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("t3a", 1'b1, 32'h0000_0005, 32'h0000_0007);
        do_op("t3b", 1'b1, 32'h0000_0007, 32'h0000_0005);
        do_op("t6", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        do_op("eq", 1'b1, 32'h8000_0000, 32'h8000_0000);
        do_op("sovf", 1'b1, 32'h8000_0000, 32'h0000_0001);

        // start held high for 10 edges: one done per accept, second accept after IDLE
        x1 = W'($urandom); y1 = W'($urandom); x2 = W'($urandom); y2 = W'($urandom);
        model(1'b0, x1, y1, r1, c, v);
        model(1'b1, x2, y2, r2, c, v);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = x1; b = y1;
        n_done = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) begin mode = 1'b1; a = x2; b = y2; end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    chk("hold.j1", 64'(j), 64'(NBYTES + 1));
                    chk("hold.r1", 64'(result), 64'(r1));
                end else begin
                    chk("hold.j2", 64'(j), 64'(2 * NBYTES + 4));
                    chk("hold.r2", 64'(result), 64'(r2));
                end
            end
            if (j == 9) start = 1'b0;
        end
        chk("hold.ndone", 64'(n_done), 64'(2));

        // async reset mid-operation
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.res", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("abort.quiet", 64'(n_done), 64'(0));
        chk("abort.res2", 64'(result), 64'(0));
        do_op("t5", 1'b0, 32'h0000_0010, 32'h0000_0020);

        for (int i = 0; i < 40; i++)
            do_op("rnd", 1'($urandom), W'($urandom), W'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
